mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath. It executes signed and unsigned multiply and divide over WIDTH+1 clock cycles using a shared shift/add-subtract datapath. It sits beside the ALU and is launched by the 4-bit ALU control code when that code selects a multiply or divide. It holds HI/LO for mfhi/mflo, and adds unsigned variants, a busy/done handshake and divide-by-zero reporting.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request, sampled at rising edge.
- op  in  4  ALU control code: 4'b1010 mult, 4'b1011 multu, 4'b1111 div, 4'b1110 divu.
- a  in  WIDTH  multiplicand or dividend; captured on accepted start.
- b  in  WIDTH  multiplier or divisor; captured on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated.
- div_by_zero  out  1  last completed op was a divide with b == 0; valid from done until next accepted start.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, state IDLE, counter 0.
- States:
  - IDLE: on start with a legal op, capture a, b, op and operand signs. Go to MUL or DIV; busy = 1.
  - MUL / DIV: WIDTH iterations, one per cycle, on absolute values. MUL is shift-add; DIV is restoring shift-subtract.
  - FIX: apply sign correction, write hi/lo, set done, go to IDLE.
- Signed rules:
  - mult: product negated if sign(a) ≠ sign(b).
  - div: quotient negated if sign(a) ≠ sign(b); remainder takes the sign of a.
  - Absolute value of -2^(WIDTH-1) is taken as unsigned 2^(WIDTH-1), with no overflow.
- Divide by zero: full latency, no early exit. lo = all ones, hi = a unchanged, div_by_zero = 1.
- Signed overflow (-2^(WIDTH-1) / -1): lo = -2^(WIDTH-1), hi = 0, div_by_zero = 0.
- Illegal op with start: ignored; no busy, no done, hi/lo unchanged.
- start while busy: ignored; captured operands are not disturbed.
- hi/lo change only at the FIX edge or on reset. They hold between operations, so mfhi/mflo read them directly.

## Timing
- start sampled high at edge k (state IDLE): busy high from edge k through edge k+WIDTH+1.
- Iterations run on edges k+1 … k+WIDTH. FIX writes hi/lo at edge k+WIDTH+1.
- At edge k+WIDTH+1: done rises, busy falls. done lasts exactly one cycle.
- A new start sampled during the done cycle (edge k+WIDTH+2) is accepted: back-to-back throughput is WIDTH+1 cycles.
- Reset mid-operation: immediate return to reset values. No done pulse; the partial result is discarded.
- div_by_zero updates at the FIX edge and clears at the next accepted start.

## Structure
- Shared package mdu_pkg holds:
  - op-code localparams OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, matching ALU control encodings;
  - state enum IDLE/MUL/DIV/FIX.
- Counter width is $clog2(WIDTH)+1.
- Single module. Datapath registers: 2·WIDTH accumulator/remainder, WIDTH operand, sign bits.
- No sub-module required; the abs/negate helper stays as a local function.

## Test plan
- WIDTH = 32, mult a=7, b=0xFFFFFFFD → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 33 edges after the start edge; busy high 33 cycles.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=7 → lo=14, hi=2.
- divu a=100, b=0 → lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 with done. Next accepted start clears div_by_zero.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Illegal op 4'b0010 with start → busy stays 0, hi/lo unchanged.
- Handshake and reset:
  - start with new operands at cycle 10 of a running mult → ignored; original result delivered.
  - start in the done cycle → second op accepted, done again 33 edges later.
  - rst at cycle 5 of a div → all outputs 0 immediately, no done.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op-codes, FSM state type and op decode helpers for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // ALU control encodings that launch the multiply/divide unit
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1111;
    localparam logic [3:0] OP_DIVU  = 4'b1110;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // True for any of the four codes this unit executes
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // True for the signed variants
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // True for the divide variants
    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iterative_if
// Description : Launch / result bundle between the datapath and the
//               multiply/divide unit. The datapath is master, the unit slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iterative
// Description : Iterative signed/unsigned multiply and divide with HI/LO
//               registers. Works on operand magnitudes through a shared
//               shift/add-subtract accumulator, then sign-corrects in FIX.
//               Latency is WIDTH+1 cycles from the accepted start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mdu_iterative_if.slave  bus
);

    localparam int                 c_CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Two's-complement negate when requested; the most negative value maps
    // onto itself, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2_if(input logic [2*WIDTH-1:0] v,
                                                     input logic               neg);
        return neg ? -v : v;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;     // {partial product | remainder, multiplier | dividend}
    logic [WIDTH-1:0]     r_opd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_a_raw;   // raw dividend, returned as HI on divide by zero
    logic                 r_is_div;
    logic                 r_b_zero;
    logic                 r_neg_q;   // negate product / quotient
    logic                 r_neg_r;   // negate remainder
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // ------------------------------------------------------------------------
    // Launch decode and operand magnitudes
    // ------------------------------------------------------------------------
    logic                 w_legal;
    logic                 w_signed;
    logic                 w_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;

    assign w_legal  = op_is_legal(bus.op);
    assign w_signed = op_is_signed(bus.op);
    assign w_div    = op_is_div(bus.op);
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_abs  = f_neg_if(bus.a, w_a_neg);
    assign w_b_abs  = f_neg_if(bus.b, w_b_neg);

    // ------------------------------------------------------------------------
    // Iteration step: shift-add for multiply, restoring subtract for divide
    // ------------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH:0]       w_div_diff;

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                         {1'b0, (r_acc[0] ? r_opd : {WIDTH{1'b0}})};
    // Remainder shifted left with the next dividend bit appended
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_trial - {1'b0, r_opd};

    // ------------------------------------------------------------------------
    // Sign correction of the finished magnitudes
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_prod_fix = f_neg2_if(r_acc, r_neg_q);
    assign w_quo_fix  = f_neg_if(r_acc[WIDTH-1:0], r_neg_q);
    assign w_rem_fix  = f_neg_if(r_acc[2*WIDTH-1:WIDTH], r_neg_r);

    // Sequencer: capture on start, iterate WIDTH times, sign-fix and write HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && w_legal) begin
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_cnt    <= '0;
                        r_a_raw  <= bus.a;
                        r_is_div <= w_div;
                        r_b_zero <= (bus.b == '0);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_div) begin
                            r_acc   <= {{WIDTH{1'b0}}, w_a_abs};
                            r_opd   <= w_b_abs;
                            r_state <= DIV;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_b_abs};
                            r_opd   <= w_a_abs;
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                DIV: begin
                    // A trial with its top bit set always exceeds the divisor,
                    // so a non-negative difference is the only subtract test.
                    if (!w_div_diff[WIDTH]) begin
                        r_acc <= {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (r_is_div) begin
                        if (r_b_zero) begin
                            r_hi  <= r_a_raw;
                            r_lo  <= {WIDTH{1'b1}};
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi  <= w_rem_fix;
                            r_lo  <= w_quo_fix;
                        end
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iterative
// Description : Self-checking bench for mdu_iterative (WIDTH = 32). A
//               latency-counting arithmetic model is compared against the
//               outputs every cycle; directed operations pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    mdu_iterative_if #(.WIDTH(W)) u_bus();

    mdu_iterative #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'b1010, 4'b1011, 4'b1111, 4'b1110};
    endfunction

    // Architectural result {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model_result(input logic [3:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        case (op)
            4'b1010: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            4'b1011: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 4'b1111) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end
                q  = sa / sb;
                r  = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {1'b0, rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Behavioural model: results appear W+1 edges after acceptance
    int          m_cnt;
    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    logic [64:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                if (m_cnt == 1) begin
                    m_dbz  <= m_pend[64];
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end else if (u_bus.start && is_legal(u_bus.op)) begin
                m_cnt  <= W + 1;
                m_busy <= 1'b1;
                m_dbz  <= 1'b0;
                m_pend <= model_result(u_bus.op, u_bus.a, u_bus.b);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(u_bus.busy), 32'(m_busy));
            check("cyc_done", 32'(u_bus.done), 32'(m_done));
            check("cyc_dbz",  32'(u_bus.div_by_zero), 32'(m_dbz));
            check("cyc_hi",   u_bus.hi, m_hi);
            check("cyc_lo",   u_bus.lo, m_lo);
        end
    end

    // Launch one op (called at a negedge), wait for done, check literals.
    // intr_at > 0 pulses a competing start at that cycle of the operation.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input int intr_at);
        int n;
        int busy_n;
        u_bus.start = 1'b1;
        u_bus.op    = op;
        u_bus.a     = a;
        u_bus.b     = b;
        @(negedge clk);
        u_bus.start = 1'b0;
        check({name, "_dbz_clr"}, 32'(u_bus.div_by_zero), 32'd0);
        n      = 1;
        busy_n = u_bus.busy ? 1 : 0;
        while (!u_bus.done && n < 100) begin
            if (n == intr_at) begin
                u_bus.start = 1'b1;
                u_bus.a     = 32'd1;
                u_bus.b     = 32'd1;
            end
            @(negedge clk);
            u_bus.start = 1'b0;
            n++;
            if (u_bus.busy) busy_n++;
        end
        check({name, "_timeout"}, 32'(n < 100), 32'd1);
        // n counts negedges from the one just after the start edge
        check({name, "_latency"}, 32'(n - 1), 32'(W + 1));
        check({name, "_busycyc"}, 32'(busy_n), 32'(W + 1));
        check({name, "_hi"},  u_bus.hi, ehi);
        check({name, "_lo"},  u_bus.lo, elo);
        check({name, "_dbz"}, 32'(u_bus.div_by_zero), 32'(edbz));
    endtask

    initial begin
        int dn;
        u_bus.start = 1'b0;
        u_bus.op    = 4'b0000;
        u_bus.a     = '0;
        u_bus.b     = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(u_bus.busy), 32'd0);
        check("rst_done", 32'(u_bus.done), 32'd0);
        check("rst_dbz",  32'(u_bus.div_by_zero), 32'd0);
        check("rst_hi",   u_bus.hi, 32'd0);
        check("rst_lo",   u_bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        run_op("mult",  4'b1010, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        // Started in the done cycle of the previous op
        run_op("multu", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("div",   4'b1111, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_nb",4'b1111, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 0);
        run_op("divu",  4'b1110, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 0);
        run_op("divu0", 4'b1110, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
        repeat (2) @(negedge clk);
        check("dbz_hold", 32'(u_bus.div_by_zero), 32'd1);
        run_op("div_ovf",4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 0);

        // Illegal op: no launch, HI/LO untouched
        u_bus.start = 1'b1;
        u_bus.op    = 4'b0010;
        u_bus.a     = 32'h5555_5555;
        u_bus.b     = 32'h3;
        @(negedge clk);
        u_bus.start = 1'b0;
        check("ill_busy", 32'(u_bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("ill_hi", u_bus.hi, 32'd0);
        check("ill_lo", u_bus.lo, 32'h8000_0000);

        // Competing start at cycle 10 of a running mult is ignored
        run_op("mult_intr", 4'b1010, 32'hFFFF_FFFC, 32'h1234_5678, 32'hFFFF_FFFF, 32'hB72E_A620, 1'b0, 10);
        @(negedge clk);

        // Reset at cycle 5 of a divide: immediate clear, no done afterwards
        u_bus.start = 1'b1;
        u_bus.op    = 4'b1111;
        u_bus.a     = 32'd1000;
        u_bus.b     = 32'd3;
        @(negedge clk);
        u_bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(u_bus.busy), 32'd1);
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("mrst_busy", 32'(u_bus.busy), 32'd0);
        check("mrst_done", 32'(u_bus.done), 32'd0);
        check("mrst_dbz",  32'(u_bus.div_by_zero), 32'd0);
        check("mrst_hi",   u_bus.hi, 32'd0);
        check("mrst_lo",   u_bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_bus.done) dn++;
        end
        check("mrst_no_done", 32'(dn), 32'd0);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
